// File: rtl/cir_peak_finder_if.sv
// AXI-stream style beat bundle (tdata/tvalid/tready/tlast)
// shared by the CIR input port and the report output port.
interface cir_peak_finder_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/cir_peak_finder.sv
// CIR peak finder: scans tlast/seq_len-delimited magnitude frames and emits
// a short peak report. Optional CIR_PEAK_NEIGHBOUR_EN adds left/right beats.
module cir_peak_finder #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                  ce_clk,
    input  logic                  ce_rst,
    input  logic                  clear,
    input  logic [IDX_WIDTH-1:0]  seq_len,
    input  logic [DATA_WIDTH-1:0] threshold,
    cir_peak_finder_if.slave      i_cir,
    cir_peak_finder_if.master     o_rpt,
    output logic [31:0]           pkt_count
);
    localparam int CW = IDX_WIDTH + 1;

`ifdef CIR_PEAK_NEIGHBOUR_EN
    typedef enum logic [2:0] {
        SCAN, EMIT0, EMIT1, EMIT2, EMIT3
    } state_t;
`else
    typedef enum logic [1:0] {
        SCAN, EMIT0, EMIT1
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_idx;
    logic [CW-1:0]           r_len;
    logic [DATA_WIDTH-1:0]   r_peak;
    logic [IDX_WIDTH-1:0]    r_pidx;
    logic [IDX_WIDTH-1:0]    r_last_idx;
    logic                    r_short;
    logic                    r_forced;
    logic [31:0]             r_pkt_count;

    logic                    w_rst;
    logic                    w_acc;
    logic                    w_first;
    logic [CW-1:0]           w_len_in;
    logic [CW-1:0]           w_len;
    logic                    w_at_end;
    logic                    w_eof;
    logic                    w_upd;
    logic                    w_done;
    logic                    w_iready;
    logic                    w_ovalid;
    logic                    w_olast;
    logic [DATA_WIDTH-1:0]   w_odata;
    logic [DATA_WIDTH-1:0]   w_beat1;

`ifdef CIR_PEAK_NEIGHBOUR_EN
    logic [DATA_WIDTH-1:0]   r_prev;
    logic [DATA_WIDTH-1:0]   r_left;
    logic [DATA_WIDTH-1:0]   r_right;
    logic                    r_pend;
`endif

    assign w_rst   = ce_rst | clear;
    assign w_acc   = i_cir.tvalid & w_iready;
    assign w_first = (r_idx == '0);

    // Effective frame length: seq_len of 0 selects 2**IDX_WIDTH.
    always_comb begin
        w_len_in = {1'b0, seq_len};
        if (seq_len == '0) begin
            w_len_in = {1'b1, {IDX_WIDTH{1'b0}}};
        end
    end

    assign w_len    = w_first ? w_len_in : r_len;
    assign w_at_end = (r_idx == (w_len - CW'(1)));
    assign w_eof    = w_acc & (i_cir.tlast | w_at_end);
    assign w_upd    = w_first | (i_cir.tdata > r_peak);

    // Flags/indices report word.
    always_comb begin
        w_beat1 = '0;
        w_beat1[31] = (r_peak > threshold);
        w_beat1[30] = r_short;
        w_beat1[29] = r_forced;
        w_beat1[IDX_WIDTH+15:16] = r_last_idx;
        w_beat1[IDX_WIDTH-1:0] = r_pidx;
    end

    // State register.
    always_ff @(posedge ce_clk) begin
        if (w_rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; the report is driven from held registers.
    always_comb begin
        w_next   = r_state;
        w_iready = 1'b0;
        w_ovalid = 1'b0;
        w_olast  = 1'b0;
        w_odata  = '0;
        w_done   = 1'b0;
        unique case (r_state)
            SCAN: begin
                w_iready = 1'b1;
                if (w_eof) begin
                    w_next = EMIT0;
                end
            end
            EMIT0: begin
                w_ovalid = 1'b1;
                w_odata  = r_peak;
                if (o_rpt.tready) begin
                    w_next = EMIT1;
                end
            end
            EMIT1: begin
                w_ovalid = 1'b1;
                w_odata  = w_beat1;
`ifdef CIR_PEAK_NEIGHBOUR_EN
                if (o_rpt.tready) begin
                    w_next = EMIT2;
                end
            end
            EMIT2: begin
                w_ovalid = 1'b1;
                w_odata  = r_left;
                if (o_rpt.tready) begin
                    w_next = EMIT3;
                end
            end
            EMIT3: begin
                w_ovalid = 1'b1;
                w_odata  = r_right;
`endif
                w_olast  = 1'b1;
                if (o_rpt.tready) begin
                    w_next = SCAN;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = SCAN;
            end
        endcase
    end

    // Frame scan: length latch, running peak, end-of-frame flags, counters.
    always_ff @(posedge ce_clk) begin
        if (w_rst) begin
            r_idx       <= '0;
            r_len       <= '0;
            r_peak      <= '0;
            r_pidx      <= '0;
            r_last_idx  <= '0;
            r_short     <= 1'b0;
            r_forced    <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            if (w_acc) begin
                if (w_first) begin
                    r_len <= w_len_in;
                end
                if (w_upd) begin
                    r_peak <= i_cir.tdata;
                    r_pidx <= r_idx[IDX_WIDTH-1:0];
                end
                if (w_eof) begin
                    r_idx      <= '0;
                    r_short    <= i_cir.tlast & ~w_at_end;
                    r_forced   <= ~i_cir.tlast & w_at_end;
                    r_last_idx <= r_idx[IDX_WIDTH-1:0];
                end else begin
                    r_idx <= r_idx + CW'(1);
                end
            end
            if (w_done) begin
                r_pkt_count <= r_pkt_count + 32'd1;
                r_idx       <= '0;
            end
        end
    end

`ifdef CIR_PEAK_NEIGHBOUR_EN
    // Neighbour capture: left from the previous sample, right from the next.
    always_ff @(posedge ce_clk) begin
        if (w_rst) begin
            r_prev  <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_pend  <= 1'b0;
        end else if (w_acc) begin
            r_prev <= i_cir.tdata;
            if (w_upd) begin
                r_left  <= w_first ? '0 : r_prev;
                r_right <= '0;
                r_pend  <= ~w_eof;
            end else if (r_pend) begin
                r_right <= i_cir.tdata;
                r_pend  <= 1'b0;
            end
        end
    end
`endif

    assign i_cir.tready = w_iready;
    assign o_rpt.tvalid = w_ovalid;
    assign o_rpt.tlast  = w_olast;
    assign o_rpt.tdata  = w_odata;
    assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_cir_peak_finder.sv
// Directed testbench for cir_peak_finder: table-driven frames plus
// hand sequences for back-pressure, mid-frame reset/clear and seq_len change.
module tb_cir_peak_finder;
    localparam int IW = 10;
`ifdef CIR_PEAK_NEIGHBOUR_EN
    localparam int NB = 4;
`else
    localparam int NB = 2;
`endif

    typedef struct {
        int                len;
        logic [31:0]       thr;
        int                n;
        int                tl;
        logic [0:7][31:0]  d;
        logic [0:3][31:0]  e;
    } rec_t;

    logic          ce_clk = 1'b0;
    logic          ce_rst;
    logic          clear;
    logic [IW-1:0] seq_len;
    logic [31:0]   threshold;
    logic [31:0]   pkt_count;

    int n_pass = 0;
    int n_tot  = 0;
    int exp_pkts = 0;
    rec_t vec[11];

    cir_peak_finder_if #(.DW(32)) s_if ();
    cir_peak_finder_if #(.DW(32)) m_if ();

    cir_peak_finder #(
        .DATA_WIDTH (32),
        .IDX_WIDTH  (IW)
    ) dut (
        .ce_clk    (ce_clk),
        .ce_rst    (ce_rst),
        .clear     (clear),
        .seq_len   (seq_len),
        .threshold (threshold),
        .i_cir     (s_if.slave),
        .o_rpt     (m_if.master),
        .pkt_count (pkt_count)
    );

    always #5 ce_clk = ~ce_clk;

    function automatic rec_t mk(
        input int len, input logic [31:0] thr, input int n, input int tl,
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
        input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
        input logic [31:0] a6, input logic [31:0] a7,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [31:0] el, input logic [31:0] er);
        rec_t r;
        r.len = len; r.thr = thr; r.n = n; r.tl = tl;
        r.d[0] = a0; r.d[1] = a1; r.d[2] = a2; r.d[3] = a3;
        r.d[4] = a4; r.d[5] = a5; r.d[6] = a6; r.d[7] = a7;
        r.e[0] = e0; r.e[1] = e1; r.e[2] = el; r.e[3] = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = l;
        while (!s_if.tready && n < 50) begin
            @(negedge ce_clk);
            n++;
        end
        if (n >= 50) chk("iready_timeout", 32'd0, 32'd1);
        @(negedge ce_clk);
    endtask

    task automatic idle_in();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
    endtask

    task automatic recv(output logic [31:0] d, output logic l);
        int n;
        n = 0;
        while (!m_if.tvalid && n < 50) begin
            @(negedge ce_clk);
            n++;
        end
        if (n >= 50) chk("ovalid_timeout", 32'd0, 32'd1);
        d = m_if.tdata;
        l = m_if.tlast;
        @(negedge ce_clk);
    endtask

    task automatic check_report(input string nm, input logic [0:3][31:0] e);
        logic [31:0] d;
        logic        l;
        chk({nm, "_latency"}, {31'd0, m_if.tvalid}, 32'd1);
        for (int b = 0; b < NB; b++) begin
            recv(d, l);
            chk($sformatf("%s_beat%0d", nm, b), d, e[b]);
            chk($sformatf("%s_last%0d", nm, b), {31'd0, l},
                {31'd0, (b == NB - 1)});
        end
        exp_pkts++;
        chk({nm, "_pkts"}, pkt_count, exp_pkts);
    endtask

    task automatic send_rec(input rec_t r);
        seq_len   = IW'(r.len);
        threshold = r.thr;
        for (int k = 0; k < r.n; k++) begin
            send(r.d[k], (k == r.tl));
        end
        idle_in();
    endtask

    initial begin
        logic [31:0]      d0;
        logic             hold_ok;
        logic [0:3][31:0] ex;

        vec[0]  = mk(8, 6, 8, 7, 1, 5, 3, 9, 2, 9, 4, 0,
                     9, 32'h8007_0003, 3, 2);
        vec[1]  = mk(8, 9, 8, 7, 1, 5, 3, 9, 2, 9, 4, 0,
                     9, 32'h0007_0003, 3, 2);
        vec[2]  = mk(8, 100, 5, 4, 7, 1, 1, 1, 1, 0, 0, 0,
                     7, 32'h4004_0000, 0, 1);
        vec[3]  = mk(8, 5, 8, 7, 2, 2, 8, 8, 1, 0, 0, 3,
                     8, 32'h8007_0002, 2, 8);
        vec[4]  = mk(4, 100, 4, -1, 0, 0, 2, 0, 0, 0, 0, 0,
                     2, 32'h2003_0002, 0, 0);
        vec[5]  = mk(4, 100, 4, -1, 3, 0, 0, 0, 0, 0, 0, 0,
                     3, 32'h2003_0000, 0, 0);
        vec[6]  = mk(1, 4, 1, -1, 5, 0, 0, 0, 0, 0, 0, 0,
                     5, 32'hA000_0000, 0, 0);
        vec[7]  = mk(1, 4, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0,
                     6, 32'h8000_0000, 0, 0);
        vec[8]  = mk(4, 100, 4, 3, 4, 8, 6, 1, 0, 0, 0, 0,
                     8, 32'h0003_0001, 4, 6);
        vec[9]  = mk(4, 2, 4, 3, 1, 2, 3, 9, 0, 0, 0, 0,
                     9, 32'h8003_0003, 3, 0);
        vec[10] = mk(16, 32'hFFFF_FFFE, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                     0, 0, 0, 0, 0, 0,
                     32'hFFFF_FFFF, 32'hC001_0000, 0, 32'hFFFF_FFFE);

        ce_rst = 1'b1;
        clear = 1'b0;
        seq_len = '0;
        threshold = '0;
        m_if.tready = 1'b1;
        idle_in();
        repeat (3) @(posedge ce_clk);
        @(negedge ce_clk);
        ce_rst = 1'b0;

        chk("rst_iready", {31'd0, s_if.tready}, 32'd1);
        chk("rst_ovalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_olast", {31'd0, m_if.tlast}, 32'd0);
        chk("rst_odata", m_if.tdata, 32'd0);
        chk("rst_pkts", pkt_count, 32'd0);

        for (int i = 0; i < 11; i++) begin
            send_rec(vec[i]);
            check_report($sformatf("vec%0d", i), vec[i].e);
        end

        // seq_len changes mid-frame only apply to the next frame.
        seq_len = IW'(4);
        threshold = 100;
        send(1, 1'b0);
        send(2, 1'b0);
        seq_len = IW'(8);
        send(3, 1'b0);
        send(4, 1'b0);
        idle_in();
        ex[0] = 4; ex[1] = 32'h2003_0003; ex[2] = 3; ex[3] = 0;
        check_report("lenchg", ex);

        // Report stalled by o_tready: data held, input back-pressured.
        m_if.tready = 1'b0;
        send_rec(vec[0]);
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'd77;
        d0 = m_if.tdata;
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge ce_clk);
            if (m_if.tdata !== d0 || m_if.tvalid !== 1'b1 ||
                s_if.tready !== 1'b0 || m_if.tlast !== 1'b0) begin
                hold_ok = 1'b0;
            end
        end
        idle_in();
        chk("stall_hold", {31'd0, hold_ok}, 32'd1);
        chk("stall_data", d0, 32'd9);
        m_if.tready = 1'b1;
        check_report("stall", vec[0].e);

        // Reset while a report is pending.
        m_if.tready = 1'b0;
        send_rec(vec[3]);
        ce_rst = 1'b1;
        @(negedge ce_clk);
        ce_rst = 1'b0;
        m_if.tready = 1'b1;
        exp_pkts = 0;
        chk("rst2_ovalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst2_odata", m_if.tdata, 32'd0);
        chk("rst2_iready", {31'd0, s_if.tready}, 32'd1);
        chk("rst2_pkts", pkt_count, 32'd0);

        // Soft clear mid-frame discards the partial frame.
        seq_len = IW'(8);
        send(100, 1'b0);
        send(200, 1'b0);
        send(300, 1'b0);
        idle_in();
        clear = 1'b1;
        @(negedge ce_clk);
        clear = 1'b0;
        chk("clr_pkts", pkt_count, 32'd0);
        send_rec(vec[0]);
        check_report("after_clr", vec[0].e);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d want %0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule
